// File: rtl/rrc_sym_sync_if.sv
// Sample-stream bundle for rrc_sym_sync: matched-filter I/Q in, one on-time
// symbol per strobe out, plus the timing-loop lock flag.
interface rrc_sym_sync_if #(
  parameter int unsigned WIQ = 16
) ();
  logic signed [WIQ-1:0] i_in;
  logic signed [WIQ-1:0] q_in;
  logic                  iq_val_i;
  logic signed [WIQ-1:0] sym_i;
  logic signed [WIQ-1:0] sym_q;
  logic                  sym_val;
  logic                  lock;

  modport master (output i_in, q_in, iq_val_i, input sym_i, sym_q, sym_val, lock);
  modport slave  (input i_in, q_in, iq_val_i, output sym_i, sym_q, sym_val, lock);
endinterface

// File: rtl/rrc_sym_sync.sv
// Early-late gate symbol timing recovery and OSF:1 decimator for the MSK RX chain.
// Optional debug outputs (dbg_err, dbg_adj) are enabled by defining SYM_SYNC_DBG_EN.
module rrc_sym_sync #(
  parameter int unsigned OSF      = 20,
  parameter int unsigned WIQ      = 16,
  parameter int unsigned EL_OFF   = 3,
  parameter int unsigned ACC_SYM  = 4,
  parameter int unsigned ERR_THR  = 0,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned ACC_W    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  rrc_sym_sync_if.slave        bus
`ifdef SYM_SYNC_DBG_EN
  ,
  output logic signed [WIQ+1:0] dbg_err,
  output logic [1:0]            dbg_adj
`endif
);

  localparam int unsigned MID = OSF / 2;
  localparam int unsigned CW  = $clog2(OSF + 2);
  localparam int unsigned EW  = WIQ + 2;
  localparam int unsigned SW  = ((ACC_W > EW) ? ACC_W : EW) + 1;
  localparam int unsigned SCW = $clog2(ACC_SYM + 1);
  localparam int unsigned LCW = $clog2(LOCK_CNT + 1);

  localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [SW-1:0] THR_P   = SW'(ERR_THR);
  localparam logic signed [SW-1:0] THR_N   = -THR_P;

  typedef enum logic [1:0] {
    ADJ_NONE = 2'b00,
    ADJ_RET  = 2'b01,
    ADJ_ADV  = 2'b10
  } adj_e;

  logic [CW-1:0]          ctr_q, ctr_d, period_q, period_d;
  logic [WIQ:0]           emag_q, emag_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [SCW-1:0]         scnt_q, scnt_d;
  logic [LCW-1:0]         lcnt_q, lcnt_d;
  logic                   lock_q, lock_d;
  logic signed [WIQ-1:0]  sym_i_q, sym_i_d, sym_q_q, sym_q_d;
  logic                   sym_val_q, sym_val_d;

  logic [WIQ:0]           mag_cur;
  logic signed [EW-1:0]   err;
  logic signed [SW-1:0]   sum, sat_w;
  adj_e                   adj;

  // |x| of the most negative code is 2^(WIQ-1); one extra bit keeps it exact.
  function automatic logic [WIQ:0] mag(input logic signed [WIQ-1:0] a,
                                       input logic signed [WIQ-1:0] b);
    logic [WIQ:0] aa, ab;
    aa = a[WIQ-1] ? (~{1'b1, a} + (WIQ+1)'(1)) : {1'b0, a};
    ab = b[WIQ-1] ? (~{1'b1, b} + (WIQ+1)'(1)) : {1'b0, b};
    return aa + ab;
  endfunction

  always_comb begin
    ctr_d     = ctr_q;
    period_d  = period_q;
    emag_d    = emag_q;
    acc_d     = acc_q;
    scnt_d    = scnt_q;
    lcnt_d    = lcnt_q;
    sym_i_d   = sym_i_q;
    sym_q_d   = sym_q_q;
    sym_val_d = 1'b0;
    adj       = ADJ_NONE;

    mag_cur = mag(bus.i_in, bus.q_in);
    err     = $signed({1'b0, mag_cur}) - $signed({1'b0, emag_q});
    sum     = $signed({{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q})
            + $signed({{(SW-EW){err[EW-1]}}, err});
    if (sum > ACC_MAX)      sat_w = ACC_MAX;
    else if (sum < ACC_MIN) sat_w = ACC_MIN;
    else                    sat_w = sum;

    if (bus.iq_val_i) begin
      if (ctr_q == period_q - CW'(1)) begin
        ctr_d    = '0;
        period_d = CW'(OSF);
      end else begin
        ctr_d = ctr_q + CW'(1);
      end

      if (ctr_q == CW'(MID)) begin
        sym_i_d   = bus.i_in;
        sym_q_d   = bus.q_in;
        sym_val_d = 1'b1;
      end

      if (ctr_q == CW'(MID - EL_OFF)) emag_d = mag_cur;

      // Evaluation sees the accumulator including this symbol's error; the
      // period change lands before this symbol's wrap, stretching only it.
      if (ctr_q == CW'(MID + EL_OFF)) begin
        acc_d  = sat_w[ACC_W-1:0];
        scnt_d = scnt_q + SCW'(1);
        if (scnt_q == SCW'(ACC_SYM - 1)) begin
          acc_d  = '0;
          scnt_d = '0;
          if (sat_w > THR_P) begin
            adj      = ADJ_RET;
            period_d = CW'(OSF + 1);
          end else if (sat_w < THR_N) begin
            adj      = ADJ_ADV;
            period_d = CW'(OSF - 1);
          end
          if (adj == ADJ_NONE)
            lcnt_d = (lcnt_q == LCW'(LOCK_CNT)) ? lcnt_q : lcnt_q + LCW'(1);
          else
            lcnt_d = '0;
        end
      end
    end

    lock_d = (lcnt_d == LCW'(LOCK_CNT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q     <= '0;
      period_q  <= CW'(OSF);
      emag_q    <= '0;
      acc_q     <= '0;
      scnt_q    <= '0;
      lcnt_q    <= '0;
      lock_q    <= 1'b0;
      sym_i_q   <= '0;
      sym_q_q   <= '0;
      sym_val_q <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      period_q  <= period_d;
      emag_q    <= emag_d;
      acc_q     <= acc_d;
      scnt_q    <= scnt_d;
      lcnt_q    <= lcnt_d;
      lock_q    <= lock_d;
      sym_i_q   <= sym_i_d;
      sym_q_q   <= sym_q_d;
      sym_val_q <= sym_val_d;
    end
  end

  assign bus.sym_i   = sym_i_q;
  assign bus.sym_q   = sym_q_q;
  assign bus.sym_val = sym_val_q;
  assign bus.lock    = lock_q;

`ifdef SYM_SYNC_DBG_EN
  logic signed [EW-1:0] dbg_err_q;
  adj_e                 dbg_adj_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_err_q <= '0;
      dbg_adj_q <= ADJ_NONE;
    end else begin
      if (bus.iq_val_i && ctr_q == CW'(MID + EL_OFF)) dbg_err_q <= err;
      dbg_adj_q <= adj;
    end
  end

  assign dbg_err = dbg_err_q;
  assign dbg_adj = dbg_adj_q;
`endif

endmodule

// File: doc/rrc_sym_sync.md
Name: rrc_sym_sync

Overview:
- Symbol timing recovery and 20:1 decimator placed directly after the √RC matched filter in the MSK receive chain.
- Consumes the matched-filter I/Q sample stream (200 MHz, 20 samples/symbol) and runs an early-late gate timing error detector on it.
- Slips its symbol counter by ±1 sample to centre the strobe on the pulse peak.
- Emits one on-time I/Q sample per symbol, with a valid strobe and a lock flag, to the demodulator/slicer.

Parameters:
- OSF, 20, input samples per symbol; even, ≥ 8.
- WIQ, 16, input/output sample width (signed).
- EL_OFF, 3, early/late offset in samples from the on-time point; 1 ≤ EL_OFF ≤ OSF/2-2.
- ACC_SYM, 4, symbols of error accumulated per loop evaluation.
- ERR_THR, 0, unsigned accumulator magnitude threshold; adjust when |acc| > ERR_THR.
- LOCK_CNT, 8, consecutive no-adjust evaluations required to assert lock.
- ACC_W, 24, error accumulator width (signed, saturating).

Ports:
- clk  in  1  system clock, 200 MHz.
- rst  in  1  asynchronous, active-high reset.
- i_in  in  WIQ  matched-filter I sample, signed.
- q_in  in  WIQ  matched-filter Q sample, signed.
- iq_val_i  in  1  input sample valid; gaps allowed.
- sym_i  out  WIQ  on-time I sample, registered.
- sym_q  out  WIQ  on-time Q sample, registered.
- sym_val  out  1  one-cycle strobe, one per symbol.
- lock  out  1  timing loop locked.

Behaviour:
- Reset: clk and rst as named; rst is asynchronous and active-high. All state clears immediately on rst: ctr=0, period=OSF, acc=0, sym_cnt=0, lock_cnt=0. Outputs reset to sym_i=0, sym_q=0, sym_val=0, lock=0. Reset mid-symbol discards all partial state; the first strobe after release is at the MID-th valid sample.
- Counter: ctr advances only on iq_val_i. When ctr==period-1 it wraps to 0, otherwise it increments. The clock never advances ctr without iq_val_i.
- Capture points: MID=OSF/2. Early sample captured at ctr==MID-EL_OFF, on-time at ctr==MID, late at ctr==MID+EL_OFF, each qualified by iq_val_i.
- Symbol output: on the valid sample with ctr==MID, the next clock registers sym_i/sym_q = i_in/q_in and pulses sym_val for 1 cycle. Latency is 1 clk; there is no backpressure. sym_i/q hold their value between strobes.
- Magnitude: mag(x) = |I|+|Q| as unsigned WIQ+1 bits. |−2^(WIQ-1)| = 2^(WIQ-1) exactly, with no wrap.
- Error: at the late capture, err = mag(late) − mag(early), signed WIQ+2 bits.
  - err is added to acc with saturation to ±(2^(ACC_W-1)−1).
  - sym_cnt then increments.
- Loop evaluation: occurs on the same valid sample once sym_cnt reaches ACC_SYM.
  - acc > ERR_THR: retard; period=OSF+1 for the current symbol only.
  - acc < −ERR_THR: advance; period=OSF−1 for the current symbol only.
  - Otherwise: no adjust.
  - After evaluation, acc=0 and sym_cnt=0.
  - period returns to OSF at the wrap following the adjusted symbol. At most one adjust is applied per evaluation.
- Lock:
  - A no-adjust evaluation increments lock_cnt, saturating at LOCK_CNT.
  - An adjust evaluation clears lock_cnt and deasserts lock on the next clk.
  - lock is registered and equals (lock_cnt==LOCK_CNT).
- Simultaneous events: the capture, error accumulate and evaluation on one valid sample all use the pre-update acc. Evaluation uses the acc that includes that sample's err.

Optional Feature:
- Macro: SYM_SYNC_DBG_EN.
- When defined, adds outputs:
  - dbg_err (WIQ+2, signed): last err, registered, updated at each late capture.
  - dbg_adj (2): 01 = retard, 10 = advance, 00 = none. One-cycle pulse at each evaluation, 00 otherwise.
  - Both reset to 0.
- When undefined, these ports and their logic are absent, and core behaviour is identical.

Test Plan:
- Reset: assert rst mid-stream at ctr=7 → outputs 0 asynchronously. After release with continuous valid, the first sym_val is 1 clk after the 11th valid sample (ctr==10).
- Constant input i=1000, q=−500, continuous valid → sym_val every 20 clk, sym_i=1000, sym_q=−500, err=0, no adjusts; lock rises after 32 symbols (8 evaluations × 4).
- Symmetric triangle pulse per 20 samples peaking at ctr=12 → evaluations at symbols 4 and 8 each retard (period 21). Peak then lands at ctr=10, after which there are no further adjusts and lock asserts 8 evaluations later.
- Same pulse peaking at ctr=8 → two advances (period 19), then centred at ctr=10; lock deasserts and re-asserts correctly if the peak is then stepped to ctr=12.
- iq_val_i high every other clk, constant input → sym_val every 40 clk with values intact; ctr holds during gaps.
- Input I=−32768, Q=−32768 early and 0 late, with ACC_W=8 → mag=65536 with no wrap; acc saturates at −127 and triggers an advance.
